// File: rtl/mc_control_if.sv
// Control-to-datapath bundle for the multicycle core: instruction/status inputs to the
// controller and the ALU OP/shamt and datapath strobes it produces.
interface mc_control_if #(
  parameter int OP_W = 4
);
  logic            run;
  logic [31:0]     instr;
  logic            zero_flag;
  logic            mem_ready;
  logic [OP_W-1:0] alu_op;
  logic [4:0]      shamt;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic            ir_write;
  logic            pc_write;
  logic            pc_write_cond;
  logic            mem_read;
  logic            mem_write;
  logic            reg_write;
  logic            reg_dst;
  logic            mem_to_reg;
  logic [1:0]      pc_src;
  logic            busy;
  logic            illegal;

  modport master (
    input  run, instr, zero_flag, mem_ready,
    output alu_op, shamt, alu_src_a, alu_src_b, ir_write, pc_write, pc_write_cond,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, pc_src, busy, illegal
  );

  modport slave (
    output run, instr, zero_flag, mem_ready,
    input  alu_op, shamt, alu_src_a, alu_src_b, ir_write, pc_write, pc_write_cond,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, pc_src, busy, illegal
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle control FSM: sequences FETCH..WRITEBACK, decodes instr into ALU OP/shamt
// and datapath selects, and handshakes with a wait-state memory port.
module mc_control #(
  parameter int OP_W      = 4,
  parameter bit TRAP_HOLD = 1'b1
) (
  input logic          clk,
  input logic          rst,
  mc_control_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR,
    MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, TRAP
  } state_t;

  typedef enum logic [OP_W-1:0] {
    ALU_SLL  = OP_W'(0),  ALU_SRL  = OP_W'(1),  ALU_SRA  = OP_W'(2),  ALU_SLLV = OP_W'(3),
    ALU_SRLV = OP_W'(4),  ALU_SRAV = OP_W'(5),  ALU_ADD  = OP_W'(6),  ALU_SUB  = OP_W'(7),
    ALU_AND  = OP_W'(8),  ALU_OR   = OP_W'(9),  ALU_XOR  = OP_W'(10), ALU_NOR  = OP_W'(11),
    ALU_SLT  = OP_W'(12), ALU_SLTU = OP_W'(13)
  } alu_op_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  typedef struct packed {
    alu_op_t    alu_op;
    logic [4:0] shamt;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic       busy;
    logic       illegal;
  } ctl_t;

  state_t     state, nxt;
  ctl_t       ctl_q, ctl_d;
  alu_op_t    r_op, i_op;
  logic       r_ok;
  logic [5:0] opcode, funct;
  logic       fetch_done, taken;

  assign opcode = bus.instr[31:26];
  assign funct  = bus.instr[5:0];

  always_comb begin
    r_ok = 1'b1;
    r_op = ALU_ADD;
    case (funct)
      6'h00:        r_op = ALU_SLL;
      6'h02:        r_op = ALU_SRL;
      6'h03:        r_op = ALU_SRA;
      6'h04:        r_op = ALU_SLLV;
      6'h06:        r_op = ALU_SRLV;
      6'h07:        r_op = ALU_SRAV;
      6'h20, 6'h21: r_op = ALU_ADD;
      6'h22, 6'h23: r_op = ALU_SUB;
      6'h24:        r_op = ALU_AND;
      6'h25:        r_op = ALU_OR;
      6'h26:        r_op = ALU_XOR;
      6'h27:        r_op = ALU_NOR;
      6'h2A:        r_op = ALU_SLT;
      6'h2B:        r_op = ALU_SLTU;
      default:      r_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_op = ALU_ADD;
    case (opcode)
      6'h0A:   i_op = ALU_SLT;
      6'h0B:   i_op = ALU_SLTU;
      6'h0C:   i_op = ALU_AND;
      6'h0D:   i_op = ALU_OR;
      6'h0E:   i_op = ALU_XOR;
      default: i_op = ALU_ADD;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (bus.run) nxt = FETCH;
      FETCH:  if (bus.mem_ready) nxt = DECODE;
      DECODE: begin
        case (opcode)
          OPC_RTYPE:                      nxt = EXEC_R;
          OPC_LW, OPC_SW:                 nxt = ADDR;
          OPC_BEQ, OPC_BNE:               nxt = BRANCH;
          OPC_J:                          nxt = JUMP;
          6'h08, 6'h09, 6'h0A, 6'h0B,
          6'h0C, 6'h0D, 6'h0E:            nxt = EXEC_I;
          default:                        nxt = TRAP;
        endcase
      end
      EXEC_R: nxt = r_ok ? WB_R : TRAP;
      EXEC_I: nxt = WB_I;
      ADDR:   nxt = (opcode == OPC_LW) ? MEM_RD : MEM_WR;
      MEM_RD: if (bus.mem_ready) nxt = MEM_WB;
      MEM_WR: if (bus.mem_ready) nxt = FETCH;
      WB_R, WB_I, MEM_WB, BRANCH, JUMP: nxt = FETCH;
      TRAP:   if (!TRAP_HOLD) nxt = FETCH;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered with it, so they stay
  // Moore (a function of the current state) yet come straight from flops.
  always_comb begin
    ctl_d        = '0;
    ctl_d.alu_op = ALU_SLL;
    case (nxt)
      FETCH:  begin ctl_d.mem_read = 1'b1; ctl_d.alu_src_b = 2'd1; ctl_d.alu_op = ALU_ADD; end
      DECODE: begin ctl_d.alu_src_b = 2'd3; ctl_d.alu_op = ALU_ADD; end
      EXEC_R: begin ctl_d.alu_src_a = 1'b1; ctl_d.alu_op = r_op; ctl_d.shamt = bus.instr[10:6]; end
      WB_R:   begin ctl_d.reg_write = 1'b1; ctl_d.reg_dst = 1'b1; end
      EXEC_I: begin ctl_d.alu_src_a = 1'b1; ctl_d.alu_src_b = 2'd2; ctl_d.alu_op = i_op; end
      WB_I:   ctl_d.reg_write = 1'b1;
      ADDR:   begin ctl_d.alu_src_a = 1'b1; ctl_d.alu_src_b = 2'd2; ctl_d.alu_op = ALU_ADD; end
      MEM_RD: ctl_d.mem_read = 1'b1;
      MEM_WB: begin ctl_d.reg_write = 1'b1; ctl_d.mem_to_reg = 1'b1; end
      MEM_WR: ctl_d.mem_write = 1'b1;
      BRANCH: begin
        ctl_d.alu_src_a     = 1'b1;
        ctl_d.alu_op        = ALU_SUB;
        ctl_d.pc_src        = 2'd1;
        ctl_d.pc_write_cond = 1'b1;
      end
      JUMP:   begin ctl_d.pc_src = 2'd2; ctl_d.pc_write = 1'b1; end
      TRAP:   ctl_d.illegal = 1'b1;
      default: ;
    endcase
    ctl_d.busy = (nxt != IDLE) && (nxt != TRAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ctl_q <= '0;
    end else begin
      state <= nxt;
      ctl_q <= ctl_d;
    end
  end

  // The fetch strobes and the branch decision track this cycle's mem_ready / zero_flag.
  assign fetch_done = (state == FETCH) && bus.mem_ready;
  assign taken      = (opcode == OPC_BNE) ? !bus.zero_flag : bus.zero_flag;

  assign bus.alu_op        = ctl_q.alu_op;
  assign bus.shamt         = ctl_q.shamt;
  assign bus.alu_src_a     = ctl_q.alu_src_a;
  assign bus.alu_src_b     = ctl_q.alu_src_b;
  assign bus.ir_write      = fetch_done;
  assign bus.pc_write      = ctl_q.pc_write | fetch_done | ((state == BRANCH) && taken);
  assign bus.pc_write_cond = ctl_q.pc_write_cond;
  assign bus.mem_read      = ctl_q.mem_read;
  assign bus.mem_write     = ctl_q.mem_write;
  assign bus.reg_write     = ctl_q.reg_write;
  assign bus.reg_dst       = ctl_q.reg_dst;
  assign bus.mem_to_reg    = ctl_q.mem_to_reg;
  assign bus.pc_src        = ctl_q.pc_src;
  assign bus.busy          = ctl_q.busy;
  assign bus.illegal       = ctl_q.illegal;
endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: table of single-instruction runs plus hand sequences
// for memory wait states, illegal instructions and reset mid-access.
module tb_mc_control;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_control_if #(.OP_W(4)) bus ();
  mc_control_if #(.OP_W(4)) bus0 ();

  mc_control #(.OP_W(4), .TRAP_HOLD(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mc_control #(.OP_W(4), .TRAP_HOLD(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  assign bus0.run       = bus.run;
  assign bus0.instr     = bus.instr;
  assign bus0.zero_flag = bus.zero_flag;
  assign bus0.mem_ready = bus.mem_ready;

  logic        in_fetch, in_fetch0;
  logic [31:0] outs;
  assign in_fetch  = bus.mem_read && (bus.alu_src_b == 2'd1);
  assign in_fetch0 = bus0.mem_read && (bus0.alu_src_b == 2'd1);
  assign outs = {8'd0, bus.alu_op, bus.shamt, bus.alu_src_a, bus.alu_src_b, bus.ir_write,
                 bus.pc_write, bus.pc_write_cond, bus.mem_read, bus.mem_write, bus.reg_write,
                 bus.reg_dst, bus.mem_to_reg, bus.pc_src, bus.busy, bus.illegal};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] funct, input logic [4:0] sh);
    return {6'h00, 5'd3, 5'd4, 5'd2, sh, funct};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op);
    return {op, 5'd3, 5'd2, 16'h07C0};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zf;
    int unsigned lat;
    logic        op_chk;
    logic [3:0]  op;
    logic        srca;
    logic [1:0]  srcb;
    logic [4:0]  sh;
    logic        pcw;
    logic [1:0]  pcsrc;
    logic        regw;
  } vec_t;

  vec_t vecs[16];

  task automatic do_reset();
    rst = 1'b1;
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs, 32'd0);
    rst = 1'b0;
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    chk("run_to_fetch", {31'd0, in_fetch}, 32'd1);
  endtask

  // Entered at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
  task automatic run_vec(input vec_t v);
    logic        regw_seen;
    logic        done;
    int unsigned lat;
    regw_seen = 1'b0;
    done = 1'b0;
    lat = 0;
    bus.instr = v.instr;
    bus.zero_flag = v.zf;
    bus.mem_ready = 1'b1;
    #1;
    chk({v.name, "_ir_write"}, {31'd0, bus.ir_write}, 32'd1);
    for (int c = 2; c <= 20 && !done; c++) begin
      @(negedge clk);
      if (bus.reg_write) regw_seen = 1'b1;
      if (c == 2) chk({v.name, "_decode"}, {bus.alu_src_b, bus.alu_op}, {2'd3, 4'b0110});
      if (c == 3) begin
        if (v.op_chk) chk({v.name, "_alu_op"}, {28'd0, bus.alu_op}, {28'd0, v.op});
        chk({v.name, "_src"}, {bus.alu_src_a, bus.alu_src_b}, {v.srca, v.srcb});
        chk({v.name, "_shamt"}, {27'd0, bus.shamt}, {27'd0, v.sh});
        chk({v.name, "_pc_write"}, {bus.pc_write, bus.pc_src}, {v.pcw, v.pcsrc});
      end
      if (in_fetch) begin
        done = 1'b1;
        lat = c - 1;
      end
    end
    chk({v.name, "_latency"}, lat, v.lat);
    chk({v.name, "_reg_write_seen"}, {31'd0, regw_seen}, {31'd0, v.regw});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        regw_seen;
    logic        done;
    int unsigned mr_cnt, m2r_cnt;

    rst = 1'b1;
    bus.run = 1'b0;
    bus.instr = '0;
    bus.zero_flag = 1'b0;
    bus.mem_ready = 1'b0;

    vecs[0]  = '{"add",   r_ins(6'h20, 5'd0), 1'b0, 4, 1'b1, 4'b0110, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1};
    vecs[1]  = '{"sll",   r_ins(6'h00, 5'd7), 1'b0, 4, 1'b1, 4'b0000, 1'b1, 2'd0, 5'd7, 1'b0, 2'd0, 1'b1};
    vecs[2]  = '{"sltu",  r_ins(6'h2B, 5'd0), 1'b0, 4, 1'b1, 4'b1101, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1};
    vecs[3]  = '{"srav",  r_ins(6'h07, 5'd5), 1'b0, 4, 1'b1, 4'b0101, 1'b1, 2'd0, 5'd5, 1'b0, 2'd0, 1'b1};
    vecs[4]  = '{"nor",   r_ins(6'h27, 5'd0), 1'b0, 4, 1'b1, 4'b1011, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1};
    vecs[5]  = '{"subu",  r_ins(6'h23, 5'd0), 1'b0, 4, 1'b1, 4'b0111, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1};
    vecs[6]  = '{"addi",  i_ins(6'h08),       1'b0, 4, 1'b1, 4'b0110, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b1};
    vecs[7]  = '{"ori",   i_ins(6'h0D),       1'b0, 4, 1'b1, 4'b1001, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b1};
    vecs[8]  = '{"slti",  i_ins(6'h0A),       1'b0, 4, 1'b1, 4'b1100, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b1};
    vecs[9]  = '{"lw",    i_ins(6'h23),       1'b0, 5, 1'b1, 4'b0110, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b1};
    vecs[10] = '{"sw",    i_ins(6'h2B),       1'b0, 4, 1'b1, 4'b0110, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0};
    vecs[11] = '{"beq_z1", i_ins(6'h04),      1'b1, 3, 1'b1, 4'b0111, 1'b1, 2'd0, 5'd0, 1'b1, 2'd1, 1'b0};
    vecs[12] = '{"bne_z1", i_ins(6'h05),      1'b1, 3, 1'b1, 4'b0111, 1'b1, 2'd0, 5'd0, 1'b0, 2'd1, 1'b0};
    vecs[13] = '{"beq_z0", i_ins(6'h04),      1'b0, 3, 1'b1, 4'b0111, 1'b1, 2'd0, 5'd0, 1'b0, 2'd1, 1'b0};
    vecs[14] = '{"bne_z0", i_ins(6'h05),      1'b0, 3, 1'b1, 4'b0111, 1'b1, 2'd0, 5'd0, 1'b1, 2'd1, 1'b0};
    vecs[15] = '{"j",     {6'h02, 26'h00007C0}, 1'b0, 3, 1'b0, 4'b0000, 1'b0, 2'd0, 5'd0, 1'b1, 2'd2, 1'b0};

    do_reset();
    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // lw with three wait states in MEM_RD
    bus.instr = i_ins(6'h23);
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.mem_ready = 1'b0;
    mr_cnt = 0;
    m2r_cnt = 0;
    done = 1'b0;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      if (c == 4) begin
        bus.mem_ready = 1'b1;
        #1;
      end
      if (in_fetch) done = 1'b1;
      else begin
        if (bus.mem_read) mr_cnt++;
        if (bus.mem_to_reg && bus.reg_write && !bus.reg_dst) m2r_cnt++;
      end
    end
    chk("lw_wait_back_to_fetch", {31'd0, done}, 32'd1);
    chk("lw_wait_mem_read_cycles", mr_cnt, 32'd4);
    chk("lw_wait_mem_to_reg_cycles", m2r_cnt, 32'd1);

    // R-type with unlisted funct: TRAP, hold vs skip
    bus.instr = r_ins(6'h3F, 5'd0);
    regw_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.reg_write || bus0.reg_write) regw_seen = 1'b1;
    end
    chk("trap_illegal", {30'd0, bus.illegal, bus.busy}, 32'd2);
    chk("trap0_illegal", {31'd0, bus0.illegal}, 32'd1);
    @(negedge clk);
    chk("trap0_returns_fetch", {30'd0, in_fetch0, bus0.illegal}, 32'd2);
    repeat (3) begin
      @(negedge clk);
      if (bus.reg_write) regw_seen = 1'b1;
    end
    chk("trap_hold_illegal", {31'd0, bus.illegal}, 32'd1);
    chk("trap_no_reg_write", {31'd0, regw_seen}, 32'd0);
    do_reset();

    // Unknown opcode goes FETCH, DECODE, TRAP
    bus.instr = i_ins(6'h3F);
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bad_opcode_trap", {31'd0, bus.illegal}, 32'd1);
    do_reset();

    // Reset while sw is stalled in MEM_WR
    bus.instr = i_ins(6'h2B);
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("sw_stall_mem_write", {31'd0, bus.mem_write}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_wr_outs", outs, 32'd0);
    chk("rst_mid_mem_wr_write", {31'd0, bus.mem_write}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_without_run", {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
